// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the fetch PC, reads instruction memory and queues {pc, instr} pairs
// for decode behind a valid/ready handshake; execute redirects flush the queue.
module fetch_queue_unit #(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned            PC_STEP    = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    output logic [ADDR_WIDTH-1:0]      o_imem_addr,
    output logic                       o_imem_en,
    input  logic [DATA_WIDTH-1:0]      i_imem_rdata,
    input  logic                       i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0]      i_redirect_target,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [ADDR_WIDTH-1:0]      o_out_pc,
    output logic [ADDR_WIDTH-1:0]      o_out_pc_plus,
    output logic [DATA_WIDTH-1:0]      o_out_instr,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_misalign
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] r_pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0] r_instr_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_misalign;

    logic                  w_full;
    logic                  w_pop;
    logic                  w_write;
    logic [ADDR_WIDTH-1:0] w_head_pc;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = (r_count != '0) & i_out_ready & ~i_redirect_valid;
    // A full queue may still accept a fetch when the head leaves in the same cycle.
    assign w_write = ~i_redirect_valid & (~w_full | w_pop);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_fetch_pc <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
        end else if (i_redirect_valid) begin
            r_fetch_pc <= {i_redirect_target[ADDR_WIDTH-1:2], 2'b00};
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_misalign <= |i_redirect_target[1:0];
        end else begin
            r_misalign <= 1'b0;
            if (w_write) begin
                r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
                r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(PC_STEP);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_write, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_write) begin
            r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
            r_instr_mem[r_wr_ptr] <= i_imem_rdata;
        end
    end

    assign w_head_pc     = r_pc_mem[r_rd_ptr];
    assign o_imem_addr   = r_fetch_pc;
    assign o_imem_en     = w_write;
    assign o_out_valid   = (r_count != '0);
    assign o_count       = r_count;
    assign o_misalign    = r_misalign;
    assign o_out_pc      = i_rst ? w_head_pc : '0;
    assign o_out_pc_plus = i_rst ? (w_head_pc + ADDR_WIDTH'(PC_STEP)) : '0;
    assign o_out_instr   = i_rst ? r_instr_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: table vectors, directed corner sequences and a random run
// checked against a queue-based reference model.
module tb_fetch_queue_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_rdata, redirect_target, out_pc, out_pc_plus, out_instr;
    logic        imem_en, redirect_valid, out_valid, out_ready, misalign;
    logic [2:0]  count;

    logic [7:0]  addr8, tgt8, pc8, pc_plus8;
    logic [31:0] rdata8, instr8;
    logic        en8, rv8, valid8, mis8;
    logic [2:0]  count8;

    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 32'h1000 + (imem_addr >> 2);
    assign rdata8     = 32'h1000 + 32'(addr8 >> 2);

    fetch_queue_unit u_dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .o_imem_addr       (imem_addr),
        .o_imem_en         (imem_en),
        .i_imem_rdata      (imem_rdata),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .o_out_valid       (out_valid),
        .i_out_ready       (out_ready),
        .o_out_pc          (out_pc),
        .o_out_pc_plus     (out_pc_plus),
        .o_out_instr       (out_instr),
        .o_count           (count),
        .o_misalign        (misalign)
    );

    fetch_queue_unit #(.ADDR_WIDTH(8)) u_dut8 (
        .i_clk             (clk),
        .i_rst             (rst),
        .o_imem_addr       (addr8),
        .o_imem_en         (en8),
        .i_imem_rdata      (rdata8),
        .i_redirect_valid  (rv8),
        .i_redirect_target (tgt8),
        .o_out_valid       (valid8),
        .i_out_ready       (1'b1),
        .o_out_pc          (pc8),
        .o_out_pc_plus     (pc_plus8),
        .o_out_instr       (instr8),
        .o_count           (count8),
        .o_misalign        (mis8)
    );

    // Reference model: the queue contents as a list of {pc, instr} plus the fetch PC.
    logic [31:0] m_pc_q[$];
    logic [31:0] m_in_q[$];
    logic [31:0] m_fetch;
    logic        m_mis;
    logic [31:0] obs_pc;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc_q.delete();
        m_in_q.delete();
        m_fetch = 32'h0;
        m_mis   = 1'b0;
    endtask

    function automatic logic model_en(input logic rdy, input logic rv);
        int sz = m_pc_q.size();
        return !rv && (sz < DEPTH || (sz > 0 && rdy));
    endfunction

    task automatic model_step(input logic rdy, input logic rv, input logic [31:0] tgt);
        int   sz;
        logic pop, wr;
        if (rv) begin
            m_pc_q.delete();
            m_in_q.delete();
            m_fetch = tgt & ~32'h3;
            m_mis   = (tgt % 4) != 0;
        end else begin
            sz  = m_pc_q.size();
            pop = sz > 0 && rdy;
            wr  = sz < DEPTH || pop;
            if (pop) begin
                void'(m_pc_q.pop_front());
                void'(m_in_q.pop_front());
            end
            if (wr) begin
                m_pc_q.push_back(m_fetch);
                m_in_q.push_back(rom(m_fetch));
                m_fetch = m_fetch + 4;
            end
            m_mis = 1'b0;
        end
    endtask

    task automatic check_model(input logic rdy, input logic rv);
        chk("valid", 64'(out_valid), 64'(m_pc_q.size() != 0));
        chk("count", 64'(count), 64'(m_pc_q.size()));
        chk("imem_addr", 64'(imem_addr), 64'(m_fetch));
        chk("imem_en", 64'(imem_en), 64'(model_en(rdy, rv)));
        chk("misalign", 64'(misalign), 64'(m_mis));
        if (m_pc_q.size() != 0) begin
            chk("out_pc", 64'(out_pc), 64'(m_pc_q[0]));
            chk("out_pc_plus", 64'(out_pc_plus), 64'(m_pc_q[0] + 32'd4));
            chk("out_instr", 64'(out_instr), 64'(m_in_q[0]));
        end
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic drive_cycle(input logic rdy, input logic rv, input logic [31:0] tgt);
        out_ready       = rdy;
        redirect_valid  = rv;
        redirect_target = tgt;
        #1;
        check_model(rdy, rv);
        obs_pc = out_pc;
        model_step(rdy, rv, tgt);
        @(negedge clk);
    endtask

    typedef struct {
        logic        rdy;
        logic        valid;
        logic [2:0]  cnt;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] addr;
        logic        en;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 3'd0, 32'h0, 32'h0,    32'h00, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 3'd1, 32'h0, 32'h1000, 32'h04, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 3'd1, 32'h4, 32'h1001, 32'h08, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 3'd1, 32'h8, 32'h1002, 32'h0C, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 3'd1, 32'hC, 32'h1003, 32'h10, 1'b1};

        rst = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        rv8 = 1'b0; tgt8 = '0;
        model_reset();
        #1;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_misalign", 64'(misalign), 64'(0));
        chk("rst_out_pc", 64'(out_pc), 64'(0));
        chk("rst_out_instr", 64'(out_instr), 64'(0));
        chk("rst_imem_addr", 64'(imem_addr), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            out_ready = tbl[i].rdy;
            #1;
            chk("tbl_valid", 64'(out_valid), 64'(tbl[i].valid));
            chk("tbl_count", 64'(count), 64'(tbl[i].cnt));
            chk("tbl_addr", 64'(imem_addr), 64'(tbl[i].addr));
            chk("tbl_en", 64'(imem_en), 64'(tbl[i].en));
            if (tbl[i].valid) begin
                chk("tbl_pc", 64'(out_pc), 64'(tbl[i].pc));
                chk("tbl_pc_plus", 64'(out_pc_plus), 64'(tbl[i].pc + 32'd4));
                chk("tbl_instr", 64'(out_instr), 64'(tbl[i].instr));
            end
            model_step(tbl[i].rdy, 1'b0, 32'h0);
            @(negedge clk);
        end

        // Asynchronous reset with two entries queued.
        drive_cycle(1'b0, 1'b0, 32'h0);
        chk("pre_rst_count", 64'(count), 64'(2));
        #2;
        rst = 1'b0;
        #1;
        chk("async_valid", 64'(out_valid), 64'(0));
        chk("async_count", 64'(count), 64'(0));
        chk("async_pc", 64'(out_pc), 64'(0));
        chk("async_pc_plus", 64'(out_pc_plus), 64'(0));
        chk("async_instr", 64'(out_instr), 64'(0));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Backpressure until full, then drain in order.
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b0, 32'h0);
        #1;
        chk("bp_count", 64'(count), 64'(4));
        chk("bp_en", 64'(imem_en), 64'(0));
        chk("bp_addr", 64'(imem_addr), 64'(16));
        chk("bp_head", 64'(out_pc), 64'(0));
        @(negedge clk);
        model_step(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            drive_cycle(1'b1, 1'b0, 32'h0);
            chk("drain_order", 64'(obs_pc), 64'(k * 4));
        end

        // Redirect with three entries queued and ready high.
        drive_cycle(1'b1, 1'b1, 32'h100);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 32'h0);
        chk("rd_pre_count", 64'(count), 64'(3));
        drive_cycle(1'b1, 1'b1, 32'h40);
        chk("rd_count", 64'(count), 64'(0));
        chk("rd_valid", 64'(out_valid), 64'(0));
        drive_cycle(1'b1, 1'b0, 32'h0);
        chk("rd_head_pc", 64'(out_pc), 64'(32'h40));
        chk("rd_head_instr", 64'(out_instr), 64'(32'h1010));

        // Misaligned target, consecutive redirects, redirect against a full queue.
        drive_cycle(1'b1, 1'b1, 32'h43);
        chk("mis_pulse", 64'(misalign), 64'(1));
        chk("mis_addr", 64'(imem_addr), 64'(32'h40));
        drive_cycle(1'b1, 1'b0, 32'h0);
        chk("mis_clear", 64'(misalign), 64'(0));
        drive_cycle(1'b1, 1'b1, 32'h80);
        drive_cycle(1'b1, 1'b1, 32'hC4);
        chk("consec_addr", 64'(imem_addr), 64'(32'hC4));
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 32'h0);
        drive_cycle(1'b1, 1'b1, 32'h200);
        chk("full_rd_count", 64'(count), 64'(0));

        // Address wrap on the 8-bit instance.
        rv8 = 1'b1; tgt8 = 8'hF8;
        drive_cycle(1'b1, 1'b0, 32'h0);
        rv8 = 1'b0;
        chk("w8_count", 64'(count8), 64'(0));
        chk("w8_addr", 64'(addr8), 64'(8'hF8));
        drive_cycle(1'b1, 1'b0, 32'h0);
        chk("w8_pc0", 64'(pc8), 64'(8'hF8));
        drive_cycle(1'b1, 1'b0, 32'h0);
        chk("w8_pc1", 64'(pc8), 64'(8'hFC));
        chk("w8_plus1", 64'(pc_plus8), 64'(8'h00));
        drive_cycle(1'b1, 1'b0, 32'h0);
        chk("w8_pc2", 64'(pc8), 64'(8'h00));
        drive_cycle(1'b1, 1'b0, 32'h0);
        chk("w8_pc3", 64'(pc8), 64'(8'h04));

        for (int i = 0; i < 400; i++) begin
            drive_cycle(($urandom % 4) != 0, ($urandom % 12) == 0, $urandom & 32'hFFF);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised successor to the single-cycle PC block: owns the fetch PC, reads instruction memory, and buffers {pc, instr} pairs in a FIFO.
- Decode consumes the FIFO through a valid/ready handshake.
- Execute can redirect fetch on a taken branch or jump. A redirect flushes the queue and reloads the PC.
- Sits between the instruction ROM and the decode/control path of the core.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, PC and memory address width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, PC increment per sequential fetch.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset); deassertion is synchronous to clk.
- imem_addr  output  ADDR_WIDTH  instruction memory address; equals fetch_pc combinationally.
- imem_en  output  1  high in cycles where imem_rdata is captured into the FIFO.
- imem_rdata  input  DATA_WIDTH  instruction word; asynchronous read, valid in the same cycle as imem_addr.
- redirect_valid  input  1  one-cycle request to redirect fetch.
- redirect_target  input  ADDR_WIDTH  new PC when redirect_valid = 1.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode accepts head entry.
- out_pc  output  ADDR_WIDTH  PC of head entry.
- out_pc_plus  output  ADDR_WIDTH  out_pc + PC_STEP, modulo 2^ADDR_WIDTH.
- out_instr  output  DATA_WIDTH  instruction of head entry.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- misalign  output  1  registered one-cycle pulse after a redirect whose target[1:0] != 0.

Behaviour:
- Reset (rst = 0, asynchronous): fetch_pc = RESET_PC; read/write pointers = 0; count = 0; out_valid = 0; misalign = 0.
- While reset is active, head-data outputs (out_pc, out_pc_plus, out_instr) are 0.
- Reset asserted mid-operation discards all queued entries immediately.
- State per cycle, priority order:
  1. redirect_valid = 1: fetch_pc <= {redirect_target[ADDR_WIDTH-1:2], 2'b00}. Pointers and count cleared. No FIFO write and no pop this cycle, even if out_ready = 1. imem_en = 0. misalign <= (redirect_target[1:0] != 0).
  2. Otherwise, write when (count < DEPTH) or (count == DEPTH and pop). A write stores {fetch_pc, imem_rdata} at the write pointer, then fetch_pc <= fetch_pc + PC_STEP with wrap from 2^ADDR_WIDTH - PC_STEP to 0. imem_en = 1.
  3. pop = out_valid & out_ready & !redirect_valid; pop advances the read pointer.
  4. Otherwise fetch_pc holds, imem_en = 0.
- Count update: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop. Never exceeds DEPTH and never underflows; pop with count == 0 is impossible because out_valid = 0.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Output timing: out_valid = (count != 0). Head outputs are driven combinationally from the storage entry at the read pointer.
  - Write-to-visible latency is 1 cycle: an entry written at edge N is visible after edge N.
  - There is no same-cycle bypass from imem_rdata to the outputs.
- Handshake: out_pc, out_instr and out_pc_plus stay stable while out_valid = 1 and out_ready = 0. out_valid never drops without a pop, a redirect, or reset.
- Throughput: one instruction per cycle sustained when out_ready is held high.
- Full-queue stall: with count == DEPTH and no pop, fetch_pc freezes and imem_en = 0.
- Redirect in the same cycle as a full-queue pop: the redirect wins; the queue is emptied.
- Redirect on consecutive cycles: each one reloads fetch_pc; the last target wins.
- misalign is 0 in every cycle not immediately following a misaligned redirect.

Test Plan:
- Reset release, RESET_PC = 0, ROM[i] = 0x1000 + i, out_ready = 1 -> out_valid rises one cycle after first write. Outputs (pc, instr) = (0, 0x1000), (4, 0x1001), (8, 0x1002)… one per cycle; out_pc_plus = out_pc + 4.
- Backpressure: out_ready = 0 for 10 cycles, DEPTH = 4 -> count reaches 4. imem_en = 0 and fetch_pc = 16 freeze; head holds pc 0 stable. Release ready -> entries 0, 4, 8, 12, 16 delivered in order with no loss or duplication.
- Redirect_valid with target 0x40 while count = 3 and out_ready = 1 -> no pop that cycle; next cycle count = 0 and out_valid = 0. The following cycle out_pc = 0x40 and out_instr = ROM[0x10].
- Redirect target 0x43 -> next fetch from 0x40; misalign = 1 for exactly one cycle, then 0.
- Wrap: ADDR_WIDTH = 8, redirect to 0xF8 -> sequence 0xF8, 0xFC, 0x00, 0x04; out_pc_plus at 0xFC = 0x00.
- Reset asserted asynchronously mid-stream with count = 2 -> out_valid = 0 and count = 0 without waiting for a clock edge. After release, fetch restarts at RESET_PC.
